// File: rtl/child_arb_pkg.sv
// Shared types and helpers for the CHILD round-robin arbiter.
package child_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    SWITCH = 2'd2
  } arb_state_t;

  // Widest requester index the arbiter supports (NUM_REQ up to 16).
  localparam int MAX_ID_W = 4;

  // Width of a requester index for a given requester count.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Token carried through the response latency pipeline.
  typedef struct packed {
    logic [MAX_ID_W-1:0] id;
    logic                valid;
  } rsp_tok_t;

endpackage

// File: rtl/child_rr_pick.sv
// Cyclic priority encoder: first set request at or after ptr, wrapping.
module child_rr_pick
  import child_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = id_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] win,
  output logic               any
);

  logic [NUM_REQ-1:0] upper;
  logic [NUM_REQ-1:0] pick_src;

  // Prefer requests at or above ptr; otherwise wrap to the lowest request.
  always_comb begin
    upper    = '0;
    pick_src = '0;
    win      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      upper[i] = req[i] && (i >= int'(ptr));
    end
    pick_src = (|upper) ? upper : req;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (pick_src[i]) begin
        win    = '0;
        win[i] = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/child_rr_arbiter.sv
// Round-robin arbiter sharing one single-bit CHILD primitive among
// NUM_REQ requesters, with a fixed-latency response return path.
module child_rr_arbiter
  import child_arb_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int MAX_BURST = 8,
  parameter  int RSP_LAT   = 1,
  localparam int ID_W      = id_w(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] din,
  output logic [NUM_REQ-1:0] gnt,
  output logic               child_i,
  input  logic               child_o,
  output logic               rsp_valid,
  output logic [ID_W-1:0]    rsp_id,
  output logic               rsp_data,
  output logic               busy
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_t         state, state_d;
  logic [NUM_REQ-1:0] gnt_d;
  logic [ID_W-1:0]    ptr, ptr_d;
  logic [ID_W-1:0]    gidx;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [NUM_REQ-1:0] win;
  logic               any;
  logic               gnt_req;
  rsp_tok_t           push_tok;
  rsp_tok_t           tail_tok;

  // Burst counter step that holds at MAX_BURST instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v < CNT_W'(MAX_BURST)) ? v + 1'b1 : v;
  endfunction

  child_rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_pick (
    .req(req),
    .ptr(ptr),
    .win(win),
    .any(any)
  );

  // Index of the current grant holder, decoded from the one-hot grant.
  always_comb begin
    gidx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) gidx = ID_W'(i);
    end
  end

  // gnt is zero outside GRANT, so both terms are zero in IDLE/SWITCH and
  // the async reset of gnt forces child_i low immediately.
  assign gnt_req = |(gnt & req);
  assign child_i = |(gnt & din);
  assign busy    = (state != IDLE);

  // Next-state, next-grant, pointer and burst-count decisions.
  always_comb begin
    state_d = state;
    gnt_d   = gnt;
    ptr_d   = ptr;
    cnt_d   = cnt;
    unique case (state)
      IDLE: begin
        if (any) begin
          state_d = GRANT;
          gnt_d   = win;
          cnt_d   = CNT_W'(1);
        end else begin
          gnt_d = '0;
        end
      end
      GRANT: begin
        if (gnt_req && (cnt < CNT_W'(MAX_BURST))) begin
          cnt_d = sat_inc(cnt);
        end else begin
          // Single exit path: a drop coinciding with the cap still
          // advances the pointer exactly once.
          state_d = SWITCH;
          gnt_d   = '0;
          cnt_d   = '0;
          ptr_d   = (gidx == ID_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
        end
      end
      SWITCH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // Arbiter state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt   <= '0;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_d;
      gnt   <= gnt_d;
      ptr   <= ptr_d;
      cnt   <= cnt_d;
    end
  end

  // Token entering the latency pipeline this cycle.
  always_comb begin
    push_tok       = '0;
    push_tok.valid = gnt_req;
    push_tok.id    = MAX_ID_W'(gidx);
  end

  // Stage p0..p(RSP_LAT-1): tokens wait while CHILD produces its output.
  generate
    if (RSP_LAT == 0) begin : g_lat0
      assign tail_tok = push_tok;
    end else begin : g_pipe
      rsp_tok_t tok_p [RSP_LAT];

      // Shift register delaying tokens by RSP_LAT cycles; reset flushes it.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < RSP_LAT; i++) tok_p[i] <= '0;
        end else begin
          tok_p[0] <= push_tok;
          for (int i = 1; i < RSP_LAT; i++) tok_p[i] <= tok_p[i-1];
        end
      end

      assign tail_tok = tok_p[RSP_LAT-1];
    end
  endgenerate

  // Response stage: capture CHILD O alongside the matured token.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= 1'b0;
    end else begin
      rsp_valid <= tail_tok.valid;
      rsp_id    <= ID_W'(tail_tok.id);
      rsp_data  <= child_o;
    end
  end

endmodule

// File: tb/tb_child_rr_arbiter.sv
// Self-checking bench for child_rr_arbiter: two instances (long burst with
// one-cycle CHILD latency, short burst with zero latency) driven in parallel.
module tb_child_rr_arbiter;

  localparam int N     = 4;
  localparam int MB_A  = 8;
  localparam int LAT_A = 1;
  localparam int MB_B  = 2;
  localparam int LAT_B = 0;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] req   = '0;
  logic [3:0] din   = '0;
  logic       flip  = 1'b0;

  logic [3:0] gnt_a, gnt_b;
  logic       ci_a, ci_b, co_a, co_b;
  logic       rv_a, rv_b, rd_a, rd_b, bz_a, bz_b;
  logic [1:0] id_a, id_b;

  // CHILD behaves as O = I, optionally inverted by the bench.
  assign co_a = ci_a ^ flip;
  assign co_b = ci_b ^ flip;

  always #5 clk = ~clk;

  child_rr_arbiter #(.NUM_REQ(N), .MAX_BURST(MB_A), .RSP_LAT(LAT_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req), .din(din), .gnt(gnt_a),
    .child_i(ci_a), .child_o(co_a), .rsp_valid(rv_a), .rsp_id(id_a),
    .rsp_data(rd_a), .busy(bz_a)
  );

  child_rr_arbiter #(.NUM_REQ(N), .MAX_BURST(MB_B), .RSP_LAT(LAT_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req), .din(din), .gnt(gnt_b),
    .child_i(ci_b), .child_o(co_b), .rsp_valid(rv_b), .rsp_id(id_b),
    .rsp_data(rd_b), .busy(bz_b)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: owner index (-1 = none), cycles held, pointer, first
  // cycle arbitration is allowed again, and a ring of pending responses
  // keyed by the cycle in which CHILD O is to be sampled.
  int  m_owner [2];
  int  m_used  [2];
  int  m_ptr   [2];
  int  m_free  [2];
  bit  m_slot_v  [2][8];
  int  m_slot_id [2][8];
  bit  e_rv [2];
  int  e_id [2];
  bit  e_rd [2];

  logic [3:0] s_gnt_a, s_gnt_b;
  logic       s_ci_a, s_ci_b, s_rv_a, s_rd_a, s_bz_a;
  logic [1:0] s_id_a;

  typedef struct packed {
    logic [3:0] req;
    logic [3:0] din;
    logic [3:0] gnt;
    logic       ci;
    logic       rv;
    logic [1:0] id;
    logic       rd;
    logic       bz;
  } vec_t;

  vec_t tbl [8];
  logic hist   [20];
  logic [3:0] hist_g [20];
  logic hist_c [20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_owner[k] = -1;
      m_used[k]  = 0;
      m_ptr[k]   = 0;
      m_free[k]  = 0;
      e_rv[k]    = 1'b0;
      e_id[k]    = 0;
      e_rd[k]    = 1'b0;
      for (int s = 0; s < 8; s++) begin
        m_slot_v[k][s]  = 1'b0;
        m_slot_id[k][s] = 0;
      end
    end
    cyc = 0;
  endfunction

  task automatic model_step(input int k, input logic [3:0] g, input logic ci,
                            input logic rv, input logic [1:0] id,
                            input logic rd, input logic bz);
    int         mb;
    int         lat;
    int         w;
    logic [3:0] eg;
    logic       eci;
    logic       ebz;
    string      tag;
    mb  = (k == 0) ? MB_A : MB_B;
    lat = (k == 0) ? LAT_A : LAT_B;
    tag = (k == 0) ? "a" : "b";
    eg  = (m_owner[k] >= 0) ? 4'(1 << m_owner[k]) : 4'b0000;
    eci = (m_owner[k] >= 0) ? din[m_owner[k]] : 1'b0;
    ebz = (m_owner[k] >= 0) || (cyc < m_free[k]);
    chk({tag, "_gnt"},       32'(g),  32'(eg));
    chk({tag, "_child_i"},   32'(ci), 32'(eci));
    chk({tag, "_busy"},      32'(bz), 32'(ebz));
    chk({tag, "_rsp_valid"}, 32'(rv), 32'(e_rv[k]));
    if (e_rv[k]) begin
      chk({tag, "_rsp_id"},   32'(id), 32'(e_id[k]));
      chk({tag, "_rsp_data"}, 32'(rd), 32'(e_rd[k]));
    end
    if (m_owner[k] >= 0 && req[m_owner[k]]) begin
      m_slot_v[k][(cyc + lat) % 8]  = 1'b1;
      m_slot_id[k][(cyc + lat) % 8] = m_owner[k];
    end
    if (m_slot_v[k][cyc % 8]) begin
      e_rv[k] = 1'b1;
      e_id[k] = m_slot_id[k][cyc % 8];
      e_rd[k] = eci ^ flip;
      m_slot_v[k][cyc % 8] = 1'b0;
    end else begin
      e_rv[k] = 1'b0;
    end
    if (m_owner[k] >= 0) begin
      m_used[k]++;
      if (!req[m_owner[k]] || m_used[k] >= mb) begin
        m_ptr[k]   = (m_owner[k] + 1) % N;
        m_owner[k] = -1;
        m_free[k]  = cyc + 2;
      end
    end else if (cyc >= m_free[k]) begin
      for (int d = 0; d < N; d++) begin
        w = (m_ptr[k] + d) % N;
        if (req[w]) begin
          m_owner[k] = w;
          m_used[k]  = 0;
          break;
        end
      end
    end
  endtask

  // One clock cycle: inputs already set; sample and check at the falling edge.
  task automatic cycle();
    @(negedge clk);
    s_gnt_a = gnt_a; s_ci_a = ci_a; s_rv_a = rv_a; s_id_a = id_a;
    s_rd_a  = rd_a;  s_bz_a = bz_a; s_gnt_b = gnt_b; s_ci_b = ci_b;
    model_step(0, gnt_a, ci_a, rv_a, id_a, rd_a, bz_a);
    model_step(1, gnt_b, ci_b, rv_b, id_b, rd_b, bz_b);
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset between clock edges; outputs must clear at once.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_gnt_a",       32'(gnt_a), 32'd0);
    chk("rst_child_i_a",   32'(ci_a),  32'd0);
    chk("rst_rsp_valid_a", 32'(rv_a),  32'd0);
    chk("rst_rsp_id_a",    32'(id_a),  32'd0);
    chk("rst_rsp_data_a",  32'(rd_a),  32'd0);
    chk("rst_busy_a",      32'(bz_a),  32'd0);
    chk("rst_gnt_b",       32'(gnt_b), 32'd0);
    chk("rst_child_i_b",   32'(ci_b),  32'd0);
    chk("rst_rsp_valid_b", 32'(rv_b),  32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int ones;
    // Single requester 2 on instance a (MAX_BURST=8, RSP_LAT=1).
    tbl[0] = '{req:4'b0100, din:4'b0100, gnt:4'b0000, ci:1'b0, rv:1'b0, id:2'd0, rd:1'b0, bz:1'b0};
    tbl[1] = '{req:4'b0100, din:4'b0100, gnt:4'b0100, ci:1'b1, rv:1'b0, id:2'd0, rd:1'b0, bz:1'b1};
    tbl[2] = '{req:4'b0100, din:4'b0100, gnt:4'b0100, ci:1'b1, rv:1'b0, id:2'd0, rd:1'b0, bz:1'b1};
    tbl[3] = '{req:4'b0100, din:4'b0100, gnt:4'b0100, ci:1'b1, rv:1'b1, id:2'd2, rd:1'b1, bz:1'b1};
    tbl[4] = '{req:4'b0000, din:4'b0100, gnt:4'b0100, ci:1'b1, rv:1'b1, id:2'd2, rd:1'b1, bz:1'b1};
    tbl[5] = '{req:4'b0000, din:4'b0100, gnt:4'b0000, ci:1'b0, rv:1'b1, id:2'd2, rd:1'b1, bz:1'b1};
    tbl[6] = '{req:4'b0000, din:4'b0100, gnt:4'b0000, ci:1'b0, rv:1'b0, id:2'd0, rd:1'b0, bz:1'b0};
    tbl[7] = '{req:4'b0000, din:4'b0000, gnt:4'b0000, ci:1'b0, rv:1'b0, id:2'd0, rd:1'b0, bz:1'b0};

    @(posedge clk);
    #1;
    do_reset();

    for (int i = 0; i < 8; i++) begin
      req  = tbl[i].req;
      din  = tbl[i].din;
      flip = 1'b0;
      cycle();
      chk("tbl_gnt",       32'(s_gnt_a), 32'(tbl[i].gnt));
      chk("tbl_child_i",   32'(s_ci_a),  32'(tbl[i].ci));
      chk("tbl_rsp_valid", 32'(s_rv_a),  32'(tbl[i].rv));
      chk("tbl_busy",      32'(s_bz_a),  32'(tbl[i].bz));
      if (tbl[i].rv) begin
        chk("tbl_rsp_id",   32'(s_id_a), 32'(tbl[i].id));
        chk("tbl_rsp_data", 32'(s_rd_a), 32'(tbl[i].rd));
      end
    end

    // Burst cap on instance a: lone requester 0 for 20 cycles.
    do_reset();
    req = 4'b0001; din = 4'b0001;
    for (int i = 0; i < 20; i++) begin
      cycle();
      hist[i] = s_gnt_a[0];
    end
    ones = 0;
    for (int i = 0; i < 20; i++) ones += int'(hist[i]);
    chk("cap_total_grant_cycles", 32'(ones), 32'd16);
    chk("cap_first_grant",  32'(hist[1]),  32'd1);
    chk("cap_last_of_burst", 32'(hist[8]), 32'd1);
    chk("cap_switch_gap",   32'(hist[9]),  32'd0);
    chk("cap_idle_gap",     32'(hist[10]), 32'd0);
    chk("cap_regrant",      32'(hist[11]), 32'd1);

    // Round-robin on instance b (MAX_BURST=2): all requesting.
    do_reset();
    req = 4'b1111; din = 4'b1111;
    for (int i = 0; i < 20; i++) begin
      cycle();
      hist_g[i] = s_gnt_b;
      hist_c[i] = s_ci_b;
    end
    chk("rr_order_0",  32'(hist_g[1]),  32'b0001);
    chk("rr_hold_0",   32'(hist_g[2]),  32'b0001);
    chk("rr_order_1",  32'(hist_g[5]),  32'b0010);
    chk("rr_order_2",  32'(hist_g[9]),  32'b0100);
    chk("rr_order_3",  32'(hist_g[13]), 32'b1000);
    chk("rr_order_0b", 32'(hist_g[17]), 32'b0001);
    for (int i = 3; i < 20; i += 4) chk("rr_switch_child_i", 32'(hist_c[i]), 32'd0);

    // Pointer wrap and no latching of a SWITCH-only pulse (instance a).
    do_reset();
    din = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      case (i)
        0, 1, 2, 3: req = 4'b0100;
        4:          req = 4'b0000;
        5:          req = 4'b1000;
        default:    req = 4'b0101;
      endcase
      cycle();
      if (i == 5) chk("ptr_switch_busy", 32'(s_bz_a), 32'd1);
      if (i == 6) chk("ptr_idle_gnt",    32'(s_gnt_a), 32'd0);
      if (i == 7) chk("ptr_wrap_winner", 32'(s_gnt_a), 32'b0001);
    end

    // Drop coinciding with the burst cap (instance a).
    do_reset();
    din = 4'b0011;
    for (int i = 0; i < 12; i++) begin
      req = (i < 8) ? 4'b0001 : ((i < 10) ? 4'b0000 : 4'b0011);
      cycle();
      if (i == 8)  chk("simul_still_granted", 32'(s_gnt_a), 32'b0001);
      if (i == 9)  chk("simul_switch_gnt",    32'(s_gnt_a), 32'd0);
      if (i == 9)  chk("simul_switch_busy",   32'(s_bz_a),  32'd1);
      if (i == 10) chk("simul_idle_busy",     32'(s_bz_a),  32'd0);
      if (i == 11) chk("simul_ptr_plus_one",  32'(s_gnt_a), 32'b0010);
    end

    // Reset mid-burst with tokens in flight and ptr left at 3.
    do_reset();
    din = 4'b0110;
    for (int i = 0; i < 7; i++) begin
      req = (i == 0) ? 4'b0100 : ((i == 1) ? 4'b0000 : 4'b0010);
      cycle();
      if (i == 5) chk("mid_gnt_before_rst", 32'(s_gnt_a), 32'b0010);
    end
    do_reset();
    req = 4'b0000;
    repeat (4) cycle();
    req = 4'b1111;
    cycle();
    cycle();
    chk("post_rst_ptr_zero", 32'(s_gnt_a), 32'b0001);

    // Randomized traffic against the model, with occasional resets.
    for (int i = 0; i < 2500; i++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 5) == 0) req[b] = ~req[b];
      end
      din  = 4'($urandom);
      flip = 1'($urandom);
      cycle();
      if ($urandom_range(0, 499) == 0) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
